// File: rtl/jp5_input_filter.sv
// ---------------------------------------------------------------------------
// jp5_input_filter
//
// Purpose:
//   Synchronises and debounces the raw JP5 header pins before they reach the
//   PIO input side. Each bit passes through a two-flop synchroniser, then a
//   per-bit stability counter that advances only on prescaler ticks. A new
//   level is accepted once it has differed from the current filtered level
//   for STABLE_SAMPLES consecutive ticks. Bits with bypass set skip the
//   debounce and follow the synchronised level every cycle.
//
// Parameters:
//   WIDTH          - number of header pins filtered
//   PRESCALE       - clk cycles per sample tick (1..65535)
//   STABLE_SAMPLES - consecutive differing ticks needed to accept (1..16)
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   reset     in   synchronous active-high reset
//   pin_in    in   [WIDTH] raw asynchronous pin levels
//   bypass    in   [WIDTH] per-bit bypass, 1 = synchronise only
//   filt_out  out  [WIDTH] debounced levels (straight from the filt register)
//   edge_rise out  [WIDTH] one-cycle pulse on a filt_out 0->1 transition
//   edge_fall out  [WIDTH] one-cycle pulse on a filt_out 1->0 transition
//
// Configuration:
//   JP5_INPUT_FILTER_EDGE_EN - when defined, builds the delayed filt copy and
//   the edge-pulse outputs. When undefined, edge_rise and edge_fall are tied
//   to 0 and filt_out behaves identically.
// ---------------------------------------------------------------------------
module jp5_input_filter #(
    parameter int WIDTH          = 32,
    parameter int PRESCALE       = 500,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] bypass,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] edge_rise,
    output logic [WIDTH-1:0] edge_fall
);

    // Counter widths with a one-bit floor so PRESCALE=1 / STABLE_SAMPLES=1
    // still produce legal vectors.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;

    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0]         sync1_q, sync1_d;
    logic [WIDTH-1:0]         sync2_q, sync2_d;
    logic [WIDTH-1:0]         filt_q,  filt_d;
    logic [PW-1:0]            ps_q,    ps_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q,   cnt_d;
    logic                     tick_s;

    // Synchroniser next-state: pins shift through two flops before use.
    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

    // Prescaler: tick on the last count, then wrap. At PRESCALE=1 the count
    // is stuck at 0, which equals PS_LAST, so every cycle is a tick.
    always_comb begin
        tick_s = (ps_q == PS_LAST);
        if (tick_s) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + PS_ONE;
        end
    end

    // Per-bit debounce next-state. The counter only ever reaches CNT_LAST,
    // at which point the next differing tick accepts the new level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (bypass[i]) begin
                // Tracking sync2 every cycle keeps filt equal to the
                // synchronised level, so dropping bypass starts clean.
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else if (tick_s) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                filt_d[i] = filt_q[i];
                cnt_d[i]  = cnt_q[i];
            end
        end
    end

    // State registers for synchroniser, prescaler, counters and filt.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            ps_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_out = filt_q;

`ifdef JP5_INPUT_FILTER_EDGE_EN
    // One-cycle-delayed copy of filt used for edge detection. It is cleared
    // together with filt so reset itself never produces a pulse.
    logic [WIDTH-1:0] filt_dly_q, filt_dly_d;

    // Delayed-copy next-state.
    always_comb begin
        filt_dly_d = filt_q;
    end

    // Delayed-copy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_dly_q <= '0;
        end else begin
            filt_dly_q <= filt_dly_d;
        end
    end

    assign edge_rise = filt_q & ~filt_dly_q;
    assign edge_fall = ~filt_q & filt_dly_q;
`else
    assign edge_rise = '0;
    assign edge_fall = '0;
`endif

endmodule

// File: tb/tb_jp5_input_filter.sv
// ---------------------------------------------------------------------------
// tb_jp5_input_filter
//
// Directed bench for jp5_input_filter. Two instances share clk/reset:
//   dut_a: PRESCALE=1, STABLE_SAMPLES=4 (latency, glitch, bypass, reset, all-bits)
//   dut_b: PRESCALE=5, STABLE_SAMPLES=2 (prescaled falling edge)
// Expected edge outputs follow JP5_INPUT_FILTER_EDGE_EN: when undefined they
// must stay 0.
// ---------------------------------------------------------------------------
module tb_jp5_input_filter;

`ifdef JP5_INPUT_FILTER_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pin_a, bypass_a, filt_a, rise_a, fall_a;
    logic [31:0] pin_b, bypass_b, filt_b, rise_b, fall_b;

    int test_cnt;
    int fail_cnt;

    jp5_input_filter #(.WIDTH(32), .PRESCALE(1), .STABLE_SAMPLES(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .pin_in    (pin_a),
        .bypass    (bypass_a),
        .filt_out  (filt_a),
        .edge_rise (rise_a),
        .edge_fall (fall_a)
    );

    jp5_input_filter #(.WIDTH(32), .PRESCALE(5), .STABLE_SAMPLES(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .pin_in    (pin_b),
        .bypass    (bypass_b),
        .filt_out  (filt_b),
        .edge_rise (rise_b),
        .edge_fall (fall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected edge value: the pattern when edges are built, else 0.
    function automatic logic [31:0] edge_exp(input logic [31:0] v);
        return EDGE_ON ? v : 32'h0000_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        test_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; sampling and driving happen 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] hist;
    logic [31:0] acc_filt, acc_edge;
    int          lat, nfall, nrise;

    initial begin
        test_cnt = 0;
        fail_cnt = 0;
        reset    = 1'b1;
        pin_a    = 32'h0;
        bypass_a = 32'h0;
        pin_b    = 32'h0;
        bypass_b = 32'h0;

        // Reset state
        repeat (3) cyc();
        check_eq("rst_filt_a", filt_a, 32'h0);
        check_eq("rst_rise_a", rise_a, 32'h0);
        check_eq("rst_fall_a", fall_a, 32'h0);
        check_eq("rst_filt_b", filt_b, 32'h0);
        reset = 1'b0;
        repeat (2) cyc();

        // Single rise on bit 0: exactly 6 cycles of latency
        pin_a[0] = 1'b1;
        repeat (5) cyc();
        check_eq("rise_lat5_filt", filt_a, 32'h0);
        cyc();
        check_eq("rise_lat6_filt", filt_a, 32'h1);
        check_eq("rise_lat6_pulse", rise_a, edge_exp(32'h1));
        check_eq("rise_lat6_nofall", fall_a, 32'h0);
        cyc();
        check_eq("rise_pulse_end", rise_a, 32'h0);

        // Glitch on bit 3: high 3 cycles then low, must be rejected
        pin_a[3] = 1'b1;
        repeat (3) cyc();
        pin_a[3] = 1'b0;
        acc_filt = 32'h0;
        acc_edge = 32'h0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            acc_filt = acc_filt | (filt_a & 32'h8);
            acc_edge = acc_edge | rise_a | fall_a;
        end
        check_eq("glitch_filt3", acc_filt, 32'h0);
        check_eq("glitch_edges", acc_edge, 32'h0);
        check_eq("glitch_bit0_held", filt_a, 32'h1);

        // Prescaled fall on dut_b bit 7: settle high first
        pin_b[7] = 1'b1;
        nrise = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (rise_b[7]) nrise++;
        end
        check_eq("pre_settle_filt", filt_b, 32'h80);
        check_eq("pre_settle_rises", 32'(nrise), edge_exp(32'h1));
        pin_b[7] = 1'b0;
        lat   = 0;
        nfall = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (fall_b[7]) nfall++;
            if (lat == 0 && filt_b[7] == 1'b0) lat = i + 1;
        end
        // Earliest: ticks at 3rd and 8th edge; latest: 7th and 12th edge.
        check_eq("pre_fall_lat_ok", 32'(lat >= 8 && lat <= 12), 32'h1);
        check_eq("pre_fall_pulses", 32'(nfall), edge_exp(32'h1));
        check_eq("pre_fall_filt", filt_b, 32'h0);

        // Bypass on bit 31: filt follows pin with 3-cycle latency
        bypass_a[31] = 1'b1;
        hist = 16'h0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) pin_a[31] = ~pin_a[31];
            hist[i] = pin_a[31];
            cyc();
            if (i >= 2) check_eq($sformatf("byp_follow_%0d", i), 32'(filt_a[31]), 32'(hist[i-2]));
        end
        pin_a[31] = 1'b1;
        repeat (5) cyc();
        check_eq("byp_settled", 32'(filt_a[31]), 32'h1);
        bypass_a[31] = 1'b0;
        acc_edge = 32'h0;
        acc_filt = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            cyc();
            acc_edge = acc_edge | ((rise_a | fall_a) & 32'h8000_0000);
            acc_filt = acc_filt & filt_a;
        end
        check_eq("byp_off_noedge", acc_edge, 32'h0);
        check_eq("byp_off_hold", acc_filt & 32'h8000_0000, 32'h8000_0000);

        // Reset in the middle of a count on bit 0
        pin_a = 32'h0;
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (2) cyc();
        pin_a[0] = 1'b1;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        check_eq("midrst_filt", filt_a, 32'h0);
        check_eq("midrst_rise", rise_a, 32'h0);
        check_eq("midrst_fall", fall_a, 32'h0);
        reset = 1'b0;
        repeat (5) cyc();
        check_eq("midrst_relat5", filt_a, 32'h0);
        check_eq("midrst_relat5_rise", rise_a, 32'h0);
        cyc();
        check_eq("midrst_relat6", filt_a, 32'h1);
        check_eq("midrst_relat6_rise", rise_a, edge_exp(32'h1));

        // All 32 bits together
        pin_a = 32'h0;
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        pin_a = 32'hFFFF_FFFF;
        repeat (5) cyc();
        check_eq("all_lat5", filt_a, 32'h0);
        cyc();
        check_eq("all_filt", filt_a, 32'hFFFF_FFFF);
        check_eq("all_rise", rise_a, edge_exp(32'hFFFF_FFFF));
        check_eq("all_nofall", fall_a, 32'h0);
        cyc();
        check_eq("all_rise_end", rise_a, 32'h0);
        pin_a = 32'h0;
        repeat (6) cyc();
        check_eq("all_fall_filt", filt_a, 32'h0);
        check_eq("all_fall", fall_a, edge_exp(32'hFFFF_FFFF));
        cyc();
        check_eq("all_fall_end", fall_a, 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
